user_sbr_router: RTL and testbench

USER_SBR_ROUTER -- requirements
Module: user_sbr_router

---
 rtl/user_sbr_router.sv | 162 ++++++++++++++++
 tb/tb_user_sbr_router.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/user_sbr_router.sv
// OBI address router: one upstream manager fanned out to NumPorts subordinates plus an
// internal error subordinate that answers unmapped addresses one cycle after the grant.
module user_sbr_router #(
  parameter int unsigned NumPorts  = 3,
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned IdWidth   = 1,
  parameter int unsigned MaxTrans  = 2,
  parameter logic [NumPorts*AddrWidth-1:0] RuleStart = '0,
  parameter logic [NumPorts*AddrWidth-1:0] RuleEnd   = '0,
  parameter logic [DataWidth-1:0]          ErrData   = 32'hBADCAB1E
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  // upstream A-channel
  input  logic                          m_req_i,
  input  logic [AddrWidth-1:0]          m_addr_i,
  input  logic                          m_we_i,
  input  logic [DataWidth/8-1:0]        m_be_i,
  input  logic [DataWidth-1:0]          m_wdata_i,
  input  logic [IdWidth-1:0]            m_aid_i,
  output logic                          m_gnt_o,
  // upstream R-channel
  output logic                          m_rvalid_o,
  output logic [DataWidth-1:0]          m_rdata_o,
  output logic                          m_err_o,
  output logic [IdWidth-1:0]            m_rid_o,
  // downstream A-channel (payload broadcast)
  output logic [NumPorts-1:0]           s_req_o,
  output logic [AddrWidth-1:0]          s_addr_o,
  output logic                          s_we_o,
  output logic [DataWidth/8-1:0]        s_be_o,
  output logic [DataWidth-1:0]          s_wdata_o,
  output logic [IdWidth-1:0]            s_aid_o,
  input  logic [NumPorts-1:0]           s_gnt_i,
  // downstream R-channel
  input  logic [NumPorts-1:0]           s_rvalid_i,
  input  logic [NumPorts*DataWidth-1:0] s_rdata_i,
  input  logic [NumPorts-1:0]           s_err_i,
  input  logic [NumPorts*IdWidth-1:0]   s_rid_i,
  // status
  output logic [15:0]                   dec_err_cnt_o,
  output logic                          spurious_o
);

  // Handshake rule (A-channel): a transfer happens in the cycle where m_req_i && m_gnt_o.
  // R-channel has no back-pressure: m_rvalid_o is consumed in the cycle it is shown.

  localparam int unsigned TgtW = $clog2(NumPorts + 1);
  localparam int unsigned CntW = $clog2(MaxTrans + 1);
  localparam logic [TgtW-1:0] ErrTgt = TgtW'(NumPorts);

  logic [CntW-1:0]      r_cnt;
  logic [TgtW-1:0]      r_tgt;
  logic                 r_err_valid;
  logic [IdWidth-1:0]   r_err_rid;
  logic [15:0]          r_dec_cnt;

  logic [TgtW-1:0]      w_tgt;
  logic                 w_allow;
  logic                 w_port_gnt;
  logic [NumPorts-1:0]  w_s_req;
  logic                 w_gnt;
  logic                 w_hs;
  logic                 w_fwd;
  logic                 w_rvalid;
  logic [DataWidth-1:0] w_rdata;
  logic                 w_rerr;
  logic [IdWidth-1:0]   w_rid;
  logic [NumPorts-1:0]  w_expect;

  // Descending scan so the lowest matching port wins.
  always_comb begin
    w_tgt = ErrTgt;
    for (int p = NumPorts - 1; p >= 0; p--) begin
      if ((m_addr_i >= RuleStart[p*AddrWidth +: AddrWidth]) &&
          (m_addr_i <  RuleEnd[p*AddrWidth +: AddrWidth])) begin
        w_tgt = TgtW'(p);
      end
    end
  end

  assign w_allow = (r_cnt < CntW'(MaxTrans)) && ((r_cnt == '0) || (w_tgt == r_tgt));

  always_comb begin
    w_port_gnt = 1'b0;
    w_s_req    = '0;
    for (int p = 0; p < NumPorts; p++) begin
      if (w_tgt == TgtW'(p)) begin
        w_port_gnt = s_gnt_i[p];
        w_s_req[p] = m_req_i && w_allow && !rst_i;
      end
    end
  end

  assign w_gnt = !rst_i && w_allow && ((w_tgt == ErrTgt) || w_port_gnt);
  assign w_hs  = m_req_i && w_gnt;

  // Only the port that owns the outstanding transactions may answer.
  always_comb begin
    w_fwd    = (r_cnt != '0) && (r_tgt != ErrTgt);
    w_rvalid = 1'b0;
    w_rdata  = '0;
    w_rerr   = 1'b0;
    w_rid    = '0;
    w_expect = '0;
    for (int p = 0; p < NumPorts; p++) begin
      if (w_fwd && (r_tgt == TgtW'(p))) begin
        w_expect[p] = 1'b1;
        w_rvalid    = s_rvalid_i[p];
        w_rdata     = s_rdata_i[p*DataWidth +: DataWidth];
        w_rerr      = s_err_i[p];
        w_rid       = s_rid_i[p*IdWidth +: IdWidth];
      end
    end
    if (r_err_valid) begin
      w_rvalid = 1'b1;
      w_rdata  = ErrData;
      w_rerr   = 1'b1;
      w_rid    = r_err_rid;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cnt       <= '0;
      r_tgt       <= '0;
      r_err_valid <= 1'b0;
      r_err_rid   <= '0;
      r_dec_cnt   <= '0;
    end else begin
      r_err_valid <= w_hs && (w_tgt == ErrTgt);
      if (w_hs) begin
        r_tgt     <= w_tgt;
        r_err_rid <= m_aid_i;
      end
      case ({w_hs, w_rvalid})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
      if (w_hs && (w_tgt == ErrTgt) && (r_dec_cnt != 16'hFFFF)) begin
        r_dec_cnt <= r_dec_cnt + 16'd1;
      end
    end
  end

  assign m_gnt_o       = w_gnt;
  assign s_req_o       = w_s_req;
  assign s_addr_o      = m_addr_i;
  assign s_we_o        = m_we_i;
  assign s_be_o        = m_be_i;
  assign s_wdata_o     = m_wdata_i;
  assign s_aid_o       = m_aid_i;
  assign m_rvalid_o    = w_rvalid && !rst_i;
  assign m_rdata_o     = w_rdata;
  assign m_err_o       = w_rerr;
  assign m_rid_o       = w_rid;
  assign dec_err_cnt_o = r_dec_cnt;
  assign spurious_o    = !rst_i && |(s_rvalid_i & ~w_expect);

endmodule

// File: tb/tb_user_sbr_router.sv
// Bench for user_sbr_router: decode/grant vector table, hand-written multi-cycle sequences,
// and a response scoreboard fed at each accepted request.
module tb_user_sbr_router;

  localparam int NP = 3;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int IW = 1;
  localparam int RW = DW + 1 + IW;
  localparam logic [NP*AW-1:0] RS = {32'h2000_0000, 32'h1000_0000, 32'h0000_0000};
  localparam logic [NP*AW-1:0] RE = {32'h4000_0000, 32'h3000_0000, 32'h1000_0000};
  localparam logic [DW-1:0] ERRD = 32'hBADCAB1E;

  logic clk_i = 1'b0;
  logic rst_i;
  logic m_req_i, m_we_i, m_gnt_o, m_rvalid_o, m_err_o;
  logic [AW-1:0] m_addr_i, s_addr_o;
  logic [DW/8-1:0] m_be_i, s_be_o;
  logic [DW-1:0] m_wdata_i, m_rdata_o, s_wdata_o;
  logic [IW-1:0] m_aid_i, m_rid_o, s_aid_o;
  logic [NP-1:0] s_req_o, s_gnt_i, s_rvalid_i, s_err_i;
  logic s_we_o;
  logic [NP*DW-1:0] s_rdata_i;
  logic [NP*IW-1:0] s_rid_i;
  logic [15:0] dec_err_cnt_o;
  logic spurious_o;

  int n_vec = 0;
  int n_err = 0;
  logic [RW-1:0] exp_q[$];

  user_sbr_router #(
    .NumPorts(NP), .AddrWidth(AW), .DataWidth(DW), .IdWidth(IW), .MaxTrans(2),
    .RuleStart(RS), .RuleEnd(RE), .ErrData(ERRD)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .m_req_i(m_req_i), .m_addr_i(m_addr_i), .m_we_i(m_we_i), .m_be_i(m_be_i),
    .m_wdata_i(m_wdata_i), .m_aid_i(m_aid_i), .m_gnt_o(m_gnt_o),
    .m_rvalid_o(m_rvalid_o), .m_rdata_o(m_rdata_o), .m_err_o(m_err_o), .m_rid_o(m_rid_o),
    .s_req_o(s_req_o), .s_addr_o(s_addr_o), .s_we_o(s_we_o), .s_be_o(s_be_o),
    .s_wdata_o(s_wdata_o), .s_aid_o(s_aid_o), .s_gnt_i(s_gnt_i),
    .s_rvalid_i(s_rvalid_i), .s_rdata_i(s_rdata_i), .s_err_i(s_err_i), .s_rid_i(s_rid_i),
    .dec_err_cnt_o(dec_err_cnt_o), .spurious_o(spurious_o)
  );

  // clock / reset
  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // scoreboard: every upstream response must match the oldest expected one
  always @(negedge clk_i) begin
    #2;
    if (m_raw_valid()) begin
      if (exp_q.size() == 0) check("unexpected_rvalid", 64'(m_rvalid_o), 64'd0);
      else check("rsp", 64'({m_rdata_o, m_err_o, m_rid_o}), 64'(exp_q.pop_front()));
    end
  end

  function automatic logic m_raw_valid();
    return m_rvalid_o === 1'b1;
  endfunction

  // reference decoder built from the bench's own rule table
  function automatic int model_tgt(input logic [AW-1:0] a);
    logic [NP*AW-1:0] rs = RS;
    logic [NP*AW-1:0] re = RE;
    for (int p = 0; p < NP; p++)
      if (a >= rs[p*AW +: AW] && a < re[p*AW +: AW]) return p;
    return NP;
  endfunction

  // driver tasks
  task automatic idle_r();
    s_rvalid_i = '0; s_err_i = '0; s_rdata_i = '0; s_rid_i = '0;
  endtask

  task automatic drive_req(input logic [AW-1:0] a, input logic [IW-1:0] aid,
                           input logic [NP-1:0] gnt);
    m_req_i = 1'b1; m_addr_i = a; m_aid_i = aid; s_gnt_i = gnt;
  endtask

  task automatic drop_req();
    m_req_i = 1'b0; s_gnt_i = '0;
  endtask

  task automatic respond(input int p, input logic [DW-1:0] d, input logic e, input logic [IW-1:0] id);
    s_rvalid_i[p] = 1'b1; s_rdata_i[p*DW +: DW] = d; s_err_i[p] = e; s_rid_i[p*IW +: IW] = id;
  endtask

  typedef struct {
    logic [AW-1:0] addr;
    logic [NP-1:0] gnt;
    logic [NP-1:0] exp_req;
    logic          exp_gnt;
  } vec_t;

  vec_t vt[9];

  initial begin
    logic [DW-1:0] d;
    logic [IW-1:0] aid;
    logic e;
    int t;
    vt[0] = '{32'h0000_0000, 3'b111, 3'b001, 1'b1};
    vt[1] = '{32'h0FFF_FFFF, 3'b001, 3'b001, 1'b1};
    vt[2] = '{32'h1000_0000, 3'b000, 3'b010, 1'b0};
    vt[3] = '{32'h1000_0000, 3'b010, 3'b010, 1'b1};
    vt[4] = '{32'h2800_0000, 3'b110, 3'b010, 1'b1};
    vt[5] = '{32'h3000_0000, 3'b100, 3'b100, 1'b1};
    vt[6] = '{32'h3FFF_FFFF, 3'b011, 3'b100, 1'b0};
    vt[7] = '{32'h4000_0000, 3'b000, 3'b000, 1'b1};
    vt[8] = '{32'hFFFF_0000, 3'b111, 3'b000, 1'b1};

    rst_i = 1'b1; m_req_i = 1'b0; m_addr_i = '0; m_we_i = 1'b0; m_be_i = '1;
    m_wdata_i = '0; m_aid_i = '0; s_gnt_i = '0; idle_r();

    // reset behaviour with activity on the inputs
    repeat (2) @(negedge clk_i);
    drive_req(32'h0, 1'b0, 3'b111); s_rvalid_i = 3'b010;
    #1;
    check("rst_s_req", 64'(s_req_o), 64'd0);
    check("rst_gnt", 64'(m_gnt_o), 64'd0);
    check("rst_rvalid", 64'(m_rvalid_o), 64'd0);
    check("rst_spurious", 64'(spurious_o), 64'd0);
    check("rst_dec_cnt", 64'(dec_err_cnt_o), 64'd0);
    drop_req(); idle_r();
    @(negedge clk_i); rst_i = 1'b0;

    // decode / grant table from idle
    foreach (vt[i]) begin
      @(negedge clk_i);
      drive_req(vt[i].addr, 1'b0, vt[i].gnt);
      #1;
      check($sformatf("tbl%0d_s_req", i), 64'(s_req_o), 64'(vt[i].exp_req));
      check($sformatf("tbl%0d_gnt", i), 64'(m_gnt_o), 64'(vt[i].exp_gnt));
      drop_req();
    end

    // single read to port 1, response two cycles later
    @(negedge clk_i); drive_req(32'h1000_0040, 1'b0, 3'b010); #1;
    check("rd1_gnt", 64'(m_gnt_o), 64'd1);
    exp_q.push_back({32'h1234_5678, 1'b0, 1'b0});
    @(negedge clk_i); drop_req();
    @(negedge clk_i); respond(1, 32'h1234_5678, 1'b0, 1'b0);
    #1; check("rd1_no_spurious", 64'(spurious_o), 64'd0);
    @(negedge clk_i); idle_r(); drive_req(32'h3000_0000, 1'b0, 3'b100); #1;
    check("rd1_cnt_zero", 64'(m_gnt_o), 64'd1);
    drop_req();

    // target switch stalls until port 0 answers
    @(negedge clk_i); drive_req(32'h0000_0100, 1'b0, 3'b001); #1;
    check("sw_gnt0", 64'(m_gnt_o), 64'd1);
    exp_q.push_back({32'hA0A0_0000, 1'b0, 1'b0});
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i); drive_req(32'h3000_0000, 1'b1, 3'b100);
      if (i == 2) respond(0, 32'hA0A0_0000, 1'b0, 1'b0);
      #1;
      check($sformatf("sw_stall%0d_gnt", i), 64'(m_gnt_o), 64'd0);
      check($sformatf("sw_stall%0d_req", i), 64'(s_req_o), 64'd0);
    end
    @(negedge clk_i); idle_r(); #1;
    check("sw_gnt2", 64'(m_gnt_o), 64'd1);
    check("sw_req2", 64'(s_req_o), 64'b100);
    exp_q.push_back({32'hC0DE_0002, 1'b0, 1'b1});
    @(negedge clk_i); drop_req();
    @(negedge clk_i); respond(2, 32'hC0DE_0002, 1'b0, 1'b1);
    @(negedge clk_i); idle_r();

    // outstanding limit of two on port 0
    @(negedge clk_i); drive_req(32'h200, 1'b0, 3'b001); #1;
    check("full_g1", 64'(m_gnt_o), 64'd1); exp_q.push_back({32'hD000_0001, 1'b0, 1'b0});
    @(negedge clk_i); #1;
    check("full_g2", 64'(m_gnt_o), 64'd1); exp_q.push_back({32'hD000_0002, 1'b0, 1'b0});
    @(negedge clk_i); #1;
    check("full_g3_blocked", 64'(m_gnt_o), 64'd0);
    check("full_req3_blocked", 64'(s_req_o), 64'd0);
    @(negedge clk_i); respond(0, 32'hD000_0001, 1'b0, 1'b0); #1;
    check("full_rsp_blocked", 64'(m_gnt_o), 64'd0);
    @(negedge clk_i); respond(0, 32'hD000_0002, 1'b0, 1'b0); #1;
    check("full_rsp_and_gnt", 64'(m_gnt_o), 64'd1); exp_q.push_back({32'hD000_0003, 1'b1, 1'b0});
    @(negedge clk_i); idle_r(); #1;
    check("full_refill", 64'(m_gnt_o), 64'd1); exp_q.push_back({32'hD000_0004, 1'b0, 1'b0});
    @(negedge clk_i); #1;
    check("full_again", 64'(m_gnt_o), 64'd0);
    drop_req();
    @(negedge clk_i); respond(0, 32'hD000_0003, 1'b1, 1'b0);
    @(negedge clk_i); respond(0, 32'hD000_0004, 1'b0, 1'b0);
    @(negedge clk_i); idle_r();

    // unmapped address answered by the error subordinate
    @(negedge clk_i); drive_req(32'hFFFF_0000, 1'b1, 3'b000); #1;
    check("err_gnt", 64'(m_gnt_o), 64'd1); exp_q.push_back({ERRD, 1'b1, 1'b1});
    @(negedge clk_i); drop_req(); #1;
    check("err_rvalid", 64'(m_rvalid_o), 64'd1);
    check("err_dec1", 64'(dec_err_cnt_o), 64'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i); drive_req(32'h5000_0000 + 32'(i), IW'(i % 2), 3'b000);
      m_we_i = (i == 1); #1;
      check($sformatf("err_b2b%0d_gnt", i), 64'(m_gnt_o), 64'd1);
      exp_q.push_back({ERRD, 1'b1, 1'(i % 2)});
    end
    @(negedge clk_i); drop_req(); m_we_i = 1'b0;
    @(negedge clk_i); #1;
    check("err_dec4", 64'(dec_err_cnt_o), 64'd4);
    check("err_drained", 64'(m_rvalid_o), 64'd0);

    // spurious responses: idle, then wrong port while port 0 is busy
    @(negedge clk_i); respond(1, 32'h5555_5555, 1'b0, 1'b0); #1;
    check("spur_idle", 64'(spurious_o), 64'd1);
    check("spur_idle_rv", 64'(m_rvalid_o), 64'd0);
    @(negedge clk_i); idle_r(); drive_req(32'h300, 1'b0, 3'b001); #1;
    check("spur_pulse_end", 64'(spurious_o), 64'd0);
    exp_q.push_back({32'h0BAD_F00D, 1'b0, 1'b0});
    @(negedge clk_i); drop_req(); respond(1, 32'h1111_1111, 1'b0, 1'b0); #1;
    check("spur_wrong_port", 64'(spurious_o), 64'd1);
    check("spur_wrong_rv", 64'(m_rvalid_o), 64'd0);
    @(negedge clk_i); idle_r(); respond(0, 32'h0BAD_F00D, 1'b0, 1'b0);
    @(negedge clk_i); idle_r();

    // random single transactions checked against the model decoder
    for (int i = 0; i < 24; i++) begin
      @(negedge clk_i); idle_r();
      m_addr_i = 32'($urandom_range(0, 32'h5FFF_FFFF));
      t = model_tgt(m_addr_i);
      aid = IW'($urandom_range(0, 1));
      d = $urandom; e = 1'($urandom_range(0, 1));
      drive_req(m_addr_i, aid, 3'b111); #1;
      check($sformatf("rnd%0d_gnt", i), 64'(m_gnt_o), 64'd1);
      check($sformatf("rnd%0d_req", i), 64'(s_req_o), (t < NP) ? 64'(1 << t) : 64'd0);
      if (t < NP) exp_q.push_back({d, e, aid});
      else exp_q.push_back({ERRD, 1'b1, aid});
      @(negedge clk_i); drop_req();
      if (t < NP) respond(t, d, e, aid);
    end
    @(negedge clk_i); idle_r();

    // saturate the decode-error counter
    for (int i = 0; i < 65536; i++) begin
      @(negedge clk_i); drive_req(32'hFFFF_0000, IW'(i % 2), 3'b000);
      exp_q.push_back({ERRD, 1'b1, 1'(i % 2)});
    end
    @(negedge clk_i); drop_req(); #1;
    check("dec_saturated", 64'(dec_err_cnt_o), 64'hFFFF);
    @(negedge clk_i);

    // reset with two transactions outstanding
    @(negedge clk_i); drive_req(32'h400, 1'b0, 3'b001);
    @(negedge clk_i); #1; check("pre_rst_g2", 64'(m_gnt_o), 64'd1);
    @(negedge clk_i); drop_req(); rst_i = 1'b1;
    @(negedge clk_i); rst_i = 1'b0; #1;
    check("post_rst_dec", 64'(dec_err_cnt_o), 64'd0);
    @(negedge clk_i); respond(0, 32'hDEAD_0000, 1'b0, 1'b0); #1;
    check("post_rst_spur", 64'(spurious_o), 64'd1);
    check("post_rst_rv", 64'(m_rvalid_o), 64'd0);
    @(negedge clk_i); idle_r(); drive_req(32'h3000_0000, 1'b0, 3'b100); #1;
    check("post_rst_cnt0", 64'(m_gnt_o), 64'd1);
    drop_req();

    repeat (3) @(negedge clk_i);
    #3;
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
